// File: rtl/rat_io_pkg.sv
// rat_io_pkg: shared port map and types for the RAT MCU I/O responder.
// Build option: DEBOUNCE_EN enables per-button debounce counters.
package rat_io_pkg;

  typedef logic [7:0] port_id_t;

  localparam port_id_t PORT_SWITCHES = 8'h20;
  localparam port_id_t PORT_PENDING  = 8'h21;
  localparam port_id_t PORT_INT_MASK = 8'h22;
  localparam port_id_t PORT_INT_ACK  = 8'h23;
  localparam port_id_t PORT_LEDS     = 8'h40;
  localparam port_id_t PORT_SSEG     = 8'h81;

  // True when an OUT instruction on this cycle targets the given port.
  function automatic logic port_write(input logic strb, input port_id_t id,
                                      input port_id_t target);
    return strb && (id == target);
  endfunction

endpackage

// File: rtl/rat_io_responder_btn_conditioner.sv
// btn_conditioner: one push-button through a 2-flop synchronizer, an optional
// debounce stage (DEBOUNCE_EN) and a rising-edge detector.
module btn_conditioner
`ifdef DEBOUNCE_EN
#(
  parameter int unsigned DB_W      = 16,
  parameter int unsigned DB_CYCLES = 50000
)
`endif
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic BTN_RAW,
  output logic BTN_LEVEL,
  output logic BTN_RISE
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= BTN_RAW;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic            acc_q;
  logic            acc_d;

  // Count consecutive cycles the synchronized level disagrees with the
  // accepted level; any agreement restarts the count.
  always_comb begin
    cnt_d = '0;
    acc_d = acc_q;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce counter and accepted level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign level = acc_q;
`else
  assign level = sync2_q;
`endif

  // Previous accepted level for edge detection; reset to 0 so a button held
  // through reset release is seen as one press.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign BTN_LEVEL = level;
  assign BTN_RISE  = level & ~prev_q;

endmodule

// File: rtl/rat_io_responder.sv
// rat_io_responder: peripheral-side responder for the RAT MCU I/O bus.
// Latches OUT writes into LED / seven-seg registers, serves IN reads, and
// turns button presses into maskable, acknowledgeable interrupts.
// Build option: DEBOUNCE_EN adds DB_CYCLES-cycle debounce per button.
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int unsigned NUM_BTN   = 4,
  parameter int unsigned DB_W      = 16,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         IN_PORT,
  output logic               INT_CU,
  input  logic [7:0]         SWITCHES,
  input  logic [NUM_BTN-1:0] BUTTONS,
  output logic [7:0]         LEDS,
  output logic [7:0]         SSEG_VAL
);

  if (NUM_BTN < 1 || NUM_BTN > 8 || DB_W < 1 || DB_CYCLES < 1) begin : g_bad_cfg
    $error("rat_io_responder: unsupported parameter set");
  end

  logic [7:0]         sw_sync1_q;
  logic [7:0]         sw_sync2_q;
  logic [7:0]         leds_q;
  logic [7:0]         sseg_q;
  logic [NUM_BTN-1:0] mask_q;
  logic [NUM_BTN-1:0] pend_q;
  logic [NUM_BTN-1:0] pend_d;
  logic [NUM_BTN-1:0] ack_clr;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_level;
  logic               int_q;

  // One conditioner per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
`ifdef DEBOUNCE_EN
    btn_conditioner #(
      .DB_W      (DB_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_cond (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .BTN_RAW   (BUTTONS[i]),
      .BTN_LEVEL (btn_level[i]),
      .BTN_RISE  (btn_rise[i])
    );
`else
    btn_conditioner u_cond (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .BTN_RAW   (BUTTONS[i]),
      .BTN_LEVEL (btn_level[i]),
      .BTN_RISE  (btn_rise[i])
    );
`endif
  end

  // Two-stage synchronizer for the slide switches.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= SWITCHES;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Writable output and mask registers; read-only and unmapped IDs fall through.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_q <= '0;
      sseg_q <= '0;
      mask_q <= '0;
    end else begin
      if (port_write(IO_STRB, PORT_ID, PORT_LEDS)) leds_q <= OUT_PORT;
      if (port_write(IO_STRB, PORT_ID, PORT_SSEG)) sseg_q <= OUT_PORT;
      if (port_write(IO_STRB, PORT_ID, PORT_INT_MASK)) mask_q <= OUT_PORT[NUM_BTN-1:0];
    end
  end

  // Pending update: write-1-to-clear first, then OR in new presses so a
  // press on the same edge as its acknowledge is not lost.
  always_comb begin
    ack_clr = '0;
    if (port_write(IO_STRB, PORT_ID, PORT_INT_ACK)) ack_clr = OUT_PORT[NUM_BTN-1:0];
    pend_d = (pend_q & ~ack_clr) | btn_rise;
  end

  // Pending flags and the registered interrupt request.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_q <= '0;
      int_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      int_q  <= |(pend_q & mask_q);
    end
  end

  // Zero-latency read mux over registered sources; unmapped IDs read 0.
  always_comb begin
    IN_PORT = '0;
    case (PORT_ID)
      PORT_SWITCHES: IN_PORT = sw_sync2_q;
      PORT_PENDING:  IN_PORT = 8'(pend_q);
      PORT_INT_MASK: IN_PORT = 8'(mask_q);
      PORT_LEDS:     IN_PORT = leds_q;
      PORT_SSEG:     IN_PORT = sseg_q;
      default:       IN_PORT = '0;
    endcase
  end

  assign LEDS     = leds_q;
  assign SSEG_VAL = sseg_q;
  assign INT_CU   = int_q;

endmodule

// File: tb/tb_rat_io_responder.sv
// tb_rat_io_responder: scoreboard bench for rat_io_responder. Stimulus pushes
// expected observations; a negedge monitor pops and compares them.
// Build option: DEBOUNCE_EN selects the debounce scenarios (DB_CYCLES=8).
module tb_rat_io_responder;
  import rat_io_pkg::*;

  localparam int SEL_IN   = 0;
  localparam int SEL_INT  = 1;
  localparam int SEL_LEDS = 2;
  localparam int SEL_SSEG = 3;

  logic       CLK      = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] PORT_ID  = '0;
  logic [7:0] OUT_PORT = '0;
  logic       IO_STRB  = 1'b0;
  logic [7:0] SWITCHES = '0;
  logic [3:0] BUTTONS  = '0;
  logic [7:0] IN_PORT;
  logic       INT_CU;
  logic [7:0] LEDS;
  logic [7:0] SSEG_VAL;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] mon_act;
  int         n_checks = 0;
  int         n_pass   = 0;

  rat_io_responder #(
    .NUM_BTN   (4),
    .DB_W      (16),
    .DB_CYCLES (8)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .IN_PORT  (IN_PORT),
    .INT_CU   (INT_CU),
    .SWITCHES (SWITCHES),
    .BUTTONS  (BUTTONS),
    .LEDS     (LEDS),
    .SSEG_VAL (SSEG_VAL)
  );

  always #5 CLK = ~CLK;

  // Monitor: compare every queued expectation against the DUT at the negedge.
  always @(negedge CLK) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.sel)
        SEL_IN:   mon_act = IN_PORT;
        SEL_INT:  mon_act = {7'b0, INT_CU};
        SEL_LEDS: mon_act = LEDS;
        default:  mon_act = SSEG_VAL;
      endcase
      n_checks++;
      if (mon_act === mon_e.exp) n_pass++;
      else $display("FAIL %s: got 0x%02h, want 0x%02h", mon_e.name, mon_act, mon_e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string name, input int sel, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] id, input logic [7:0] exp);
    PORT_ID = id;
    push(name, SEL_IN, exp);
    tick();
  endtask

  // Assert reset between clock edges and check outputs before any rising edge.
  task automatic reset_mid();
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (LEDS === 8'h00) n_pass++;
    else $display("FAIL rst_leds_async: got 0x%02h, want 0x00", LEDS);
    n_checks++;
    if (INT_CU === 1'b0) n_pass++;
    else $display("FAIL rst_int_async: got %b, want 0", INT_CU);
    PORT_ID = PORT_PENDING;
    push("rst_leds", SEL_LEDS, 8'h00);
    push("rst_sseg", SEL_SSEG, 8'h00);
    push("rst_int", SEL_INT, 8'h00);
    push("rst_pend", SEL_IN, 8'h00);
    tick();
    PORT_ID = PORT_INT_MASK;
    push("rst_mask", SEL_IN, 8'h00);
    tick();
    RESET_N = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    RESET_N = 1'b1;
    PORT_ID = PORT_LEDS;
    push("por_leds", SEL_LEDS, 8'h00);
    push("por_sseg", SEL_SSEG, 8'h00);
    push("por_int", SEL_INT, 8'h00);
    push("por_rd_leds", SEL_IN, 8'h00);
    tick();

    // Register writes and reads.
    wr(PORT_LEDS, 8'hA5);
    push("wr_leds", SEL_LEDS, 8'hA5);
    tick();
    wr(PORT_SSEG, 8'h3C);
    n_checks++;
    if (SSEG_VAL === 8'h3C) n_pass++;
    else $display("FAIL wr_sseg_direct: got 0x%02h, want 0x3c", SSEG_VAL);
    push("wr_sseg", SEL_SSEG, 8'h3C);
    push("wr_leds_kept", SEL_LEDS, 8'hA5);
    tick();
    rd("rd_leds", PORT_LEDS, 8'hA5);
    rd("rd_sseg", PORT_SSEG, 8'h3C);
    rd("rd_unmapped_7f", 8'h7F, 8'h00);
    rd("rd_unmapped_00", 8'h00, 8'h00);
    rd("rd_mask_reset", PORT_INT_MASK, 8'h00);
    wr(PORT_SWITCHES, 8'hFF);
    wr(PORT_PENDING, 8'hFF);
    wr(8'h41, 8'h00);
    push("ro_leds", SEL_LEDS, 8'hA5);
    push("ro_sseg", SEL_SSEG, 8'h3C);
    tick();
    rd("ro_pend", PORT_PENDING, 8'h00);
    rd("ro_sw", PORT_SWITCHES, 8'h00);
    wr(PORT_INT_MASK, 8'hFF);
    rd("mask_width", PORT_INT_MASK, 8'h0F);

    // Switch synchronizer latency.
    PORT_ID  = PORT_SWITCHES;
    SWITCHES = 8'h5A;
    push("sw_edge0", SEL_IN, 8'h00);
    tick();
    push("sw_edge1", SEL_IN, 8'h00);
    tick();
    push("sw_edge2", SEL_IN, 8'h5A);
    tick();
    n_checks++;
    if (IN_PORT === 8'h5A) n_pass++;
    else $display("FAIL sw_direct: got 0x%02h, want 0x5a", IN_PORT);

`ifndef DEBOUNCE_EN
    // Button 0 press latency into PENDING and INT_CU.
    wr(PORT_INT_MASK, 8'h01);
    PORT_ID = PORT_PENDING;
    BUTTONS = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("irq_int_%0d", i), SEL_INT, (i >= 4) ? 8'h01 : 8'h00);
      push($sformatf("irq_pend_%0d", i), SEL_IN, (i >= 3) ? 8'h01 : 8'h00);
      tick();
    end

    // Acknowledge clears PENDING at once, INT_CU one edge later.
    wr(PORT_INT_ACK, 8'h01);
    PORT_ID = PORT_PENDING;
    push("ack_pend", SEL_IN, 8'h00);
    push("ack_int_lag", SEL_INT, 8'h01);
    tick();
    push("ack_int_clr", SEL_INT, 8'h00);
    tick();

    // Masked button sets PENDING without raising INT_CU.
    BUTTONS = 4'b0011;
    repeat (4) tick();
    push("b1_pend", SEL_IN, 8'h02);
    push("b1_int", SEL_INT, 8'h00);
    tick();

    // Press and acknowledge on the same edge: the press wins.
    BUTTONS = 4'b0010;
    repeat (3) tick();
    BUTTONS = 4'b0011;
    tick();
    tick();
    wr(PORT_INT_ACK, 8'h03);
    PORT_ID = PORT_PENDING;
    push("coll_pend", SEL_IN, 8'h01);
    tick();
    push("coll_int", SEL_INT, 8'h01);
    tick();

    // Build PENDING=0x3, LEDS=0xFF, then reset mid-cycle.
    BUTTONS = 4'b0001;
    repeat (3) tick();
    BUTTONS = 4'b0011;
    repeat (3) tick();
    wr(PORT_LEDS, 8'hFF);
    PORT_ID = PORT_PENDING;
    push("pre_rst_pend", SEL_IN, 8'h03);
    push("pre_rst_leds", SEL_LEDS, 8'hFF);
    tick();
    reset_mid();

    // Buttons held through reset release register as one press each.
    PORT_ID = PORT_PENDING;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("held_pend_%0d", i), SEL_IN, (i >= 3) ? 8'h03 : 8'h00);
      tick();
    end
    push("held_int_masked", SEL_INT, 8'h00);
    tick();
`else
    // Debounce with DB_CYCLES=8.
    wr(PORT_INT_MASK, 8'h01);
    PORT_ID = PORT_PENDING;
    BUTTONS = 4'b0001;
    repeat (5) tick();
    BUTTONS = 4'b0000;
    repeat (20) tick();
    push("db_glitch", SEL_IN, 8'h00);
    tick();

    BUTTONS = 4'b0001;
    repeat (10) tick();
    push("db_pre_accept", SEL_IN, 8'h00);
    tick();
    push("db_accept", SEL_IN, 8'h01);
    tick();
    repeat (20) tick();
    push("db_hold_pend", SEL_IN, 8'h01);
    push("db_hold_int", SEL_INT, 8'h01);
    tick();

    wr(PORT_INT_ACK, 8'h01);
    PORT_ID = PORT_PENDING;
    repeat (20) tick();
    push("db_ack_no_retrig", SEL_IN, 8'h00);
    tick();

    BUTTONS = 4'b0000;
    repeat (3) tick();
    BUTTONS = 4'b0001;
    repeat (2) tick();
    BUTTONS = 4'b0000;
    repeat (2) tick();
    BUTTONS = 4'b0001;
    tick();
    BUTTONS = 4'b0000;
    repeat (20) tick();
    push("db_bounce_release", SEL_IN, 8'h00);
    tick();
    BUTTONS = 4'b0001;
    repeat (20) tick();
    push("db_clean_press", SEL_IN, 8'h01);
    tick();
    wr(PORT_INT_ACK, 8'h01);
    PORT_ID = PORT_PENDING;
    repeat (3) tick();
    push("db_single_set", SEL_IN, 8'h00);
    push("db_int_pre_rst", SEL_INT, 8'h00);
    tick();
    reset_mid();
`endif

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass != n_checks || n_checks == 0) begin
      $display("FAIL summary: %0d of %0d checks failed", n_checks - n_pass, n_checks);
      $fatal(1);
    end
    $finish;
  end

endmodule
